esop_tt_capture: RTL and testbench
==================================

# esop_tt_capture

Sequential truth-table capture stage placed directly upstream of a combinational single-output ESOP network (10 inputs `x0`..`x9`, output `o`). It sweeps every input minterm into the network, samples the returned output, and packs the results into `WORD_W`-bit words. The words leave on a valid/ready stream together with a running ones-count. This stream is what the equivalence checker uses to compare a synthesized ESOP against its specification function.

## Interface
Parameters:
- `NIN`, default 10: number of ESOP inputs. Legal range is 5..16.
- `WORD_W`, default 32: truth-table word width. Must be a power of two and ≤ 2^NIN.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep. Honoured only in IDLE.
- `busy`  out  1  high in SWEEP or EMIT.
- `x`  out  NIN  registered minterm driven to the ESOP inputs. `x[i]` drives `xi`.
- `f`  in  1  ESOP output `o`. Combinational from `x`, sampled the same cycle.
- `word_data`  out  WORD_W  packed truth-table word. Bit k = f(pattern base+k).
- `word_idx`  out  NIN  index of the current word, 0..2^NIN/WORD_W−1.
- `word_valid`  out  1  word available.
- `word_ready`  in  1  consumer accepts the word.
- `ones_count`  out  NIN+1  number of minterms with f=1, cumulative over the current sweep.
- `done`  out  1  one-cycle pulse when the sweep completes.

## Operation
- FSM states: IDLE, SWEEP, EMIT.
- IDLE:
  - `x`=0, `busy`=0.
  - `start`=1 moves to SWEEP next cycle and clears the shift register, `ones_count` and `word_idx`.
- SWEEP, each cycle:
  - Shift `f` into bit position `x mod WORD_W` of the shift register, so the lowest pattern lands at the LSB.
  - Add `f` to `ones_count`.
  - If `x mod WORD_W` = WORD_W−1: go to EMIT and hold `x`. Otherwise `x`←`x`+1.
- EMIT:
  - `word_valid`=1, with `word_data` and `word_idx` stable until `word_valid && word_ready`.
  - On accept, if `word_idx` is the last word: go to IDLE, pulse `done`, and set `x`←0.
  - On accept otherwise: `x`←`x`+1, `word_idx`←`word_idx`+1, return to SWEEP.
- `x` never changes while in EMIT, so `f` is not sampled again during a stall.
- `start` is ignored while `busy` is high.
- `ones_count` and the last `word_data` hold their values in IDLE until the next `start`.
- Widths:
  - The `x` counter is NIN bits and wraps only through the explicit clear.
  - `ones_count` reaches at most 2^NIN without overflow.

## Timing
- Reset values: `x`=0, `busy`=0, `word_valid`=0, `word_data`=0, `word_idx`=0, `ones_count`=0, `done`=0. State is IDLE.
- Reset takes priority over everything, including mid-sweep and mid-EMIT. `word_valid` drops the cycle after `rst` is sampled high.
- First minterm sampled: cycle S+1, where S is the cycle `start` is sampled. `busy` is high from S+1.
- Each word costs WORD_W SWEEP cycles plus ≥1 EMIT cycle.
- With `word_ready` tied high, defaults: the first `word_valid` is at S+33. `done` pulses at S+1+32·33 = S+1057, in the cycle after the final accept. `busy` is low in that same cycle.
- `word_valid` never depends combinationally on `word_ready`.
- `ones_count` is final when `done` pulses.
- A `start` arriving in the same cycle as `done` is accepted, because the FSM is already in IDLE.

## Test plan
- f driven by the bench model f=x[0], ready tied high -> 32 words, each 0xAAAAAAAA; `word_idx` runs 0..31; `ones_count`=512; `done` at S+1057.
- f=x[9] -> words 0..15 = 0x00000000 and words 16..31 = 0xFFFFFFFF; `ones_count`=512.
- f=0 constant, with `word_ready` low for 5 cycles on word 3 -> `word_valid`, `word_data`=0 and `word_idx`=3 held for 6 cycles; `x` frozen at 127; `done` pulse delayed by 5 cycles; `ones_count`=0.
- f=(x==10'h3FF) -> only word 31 = 0x80000000; `ones_count`=1. Then assert `start` mid-sweep -> no effect on words or count.
- `rst` asserted in EMIT of word 7, then `start` -> all outputs at reset values the cycle after; the new sweep restarts at `word_idx`=0 with `ones_count` cleared.
- `start` in the same cycle as `done` -> second sweep begins immediately with an identical word stream.

Source files
------------

// File: rtl/esop_tt_capture_if.sv
// Truth-table word stream leaving the capture stage: packed word, its index,
// running ones-count and the end-of-sweep pulse, with valid/ready flow control.
interface esop_tt_capture_if #(
  parameter int NIN    = 10,
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] word_data;
  logic [NIN-1:0]    word_idx;
  logic              word_valid;
  logic              word_ready;
  logic [NIN:0]      ones_count;
  logic              done;

  modport master (
    output word_data, word_idx, word_valid, ones_count, done,
    input  word_ready
  );

  modport slave (
    input  word_data, word_idx, word_valid, ones_count, done,
    output word_ready
  );
endinterface

// File: rtl/esop_tt_capture.sv
// Sweeps all 2^NIN minterms through an external ESOP network and packs f into words.
// WORD_W sweep cycles per word, then holds in EMIT (x frozen) until the word is accepted.
module esop_tt_capture #(
  parameter int NIN    = 10,
  parameter int WORD_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic [NIN-1:0]  x,
  input  logic            f,
  esop_tt_capture_if.master wif
);
  localparam int              NWORDS   = (1 << NIN) / WORD_W;
  localparam int              LW       = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [NIN-1:0]  LOW_MASK = NIN'(WORD_W - 1);
  localparam logic [NIN-1:0]  LAST_IDX = NIN'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, EMIT} state_e;

  state_e            state_q, state_d;
  logic [NIN-1:0]    x_q, x_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [NIN-1:0]    idx_q, idx_d;
  logic [NIN:0]      ones_q, ones_d;
  logic              done_q, done_d;
  logic [LW-1:0]     bitpos;

  assign bitpos = LW'(x_q & LOW_MASK);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          x_d     = '0;
          shreg_d = '0;
          idx_d   = '0;
          ones_d  = '0;
        end
      end
      SWEEP: begin
        shreg_d[bitpos] = f;
        ones_d          = ones_q + (NIN+1)'(f);
        // Last bit of the word: stop advancing x so f is not resampled during a stall.
        if ((x_q & LOW_MASK) == LOW_MASK) begin
          state_d = EMIT;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      EMIT: begin
        if (wif.word_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
            x_d     = '0;
          end else begin
            state_d = SWEEP;
            x_d     = x_q + 1'b1;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      shreg_q <= '0;
      idx_q   <= '0;
      ones_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      done_q  <= done_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign x              = x_q;
  assign wif.word_valid = (state_q == EMIT);
  assign wif.word_data  = shreg_q;
  assign wif.word_idx   = idx_q;
  assign wif.ones_count = ones_q;
  assign wif.done       = done_q;
endmodule

// File: tb/tb_esop_tt_capture.sv
// Bench for esop_tt_capture: the ESOP is modelled as a lookup table filled from a rule,
// and the expected word stream and ones-count are derived from that table.
module tb_esop_tt_capture;
  localparam int NIN    = 10;
  localparam int WORD_W = 32;
  localparam int NMIN   = 1 << NIN;
  localparam int NWORDS = NMIN / WORD_W;

  logic           clk;
  logic           rst;
  logic           start;
  logic           busy;
  logic [NIN-1:0] x;
  logic           f;
  logic           lut [NMIN];

  int compared;
  int mismatched;

  esop_tt_capture_if #(.NIN(NIN), .WORD_W(WORD_W)) wif ();

  esop_tt_capture #(.NIN(NIN), .WORD_W(WORD_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .x     (x),
    .f     (f),
    .wif   (wif)
  );

  assign f = lut[x];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0: f=x0  1: f=x9  2: f=0  3: f=(x==all ones)  4: random function
  task automatic set_lut(input int mode);
    for (int m = 0; m < NMIN; m++) begin
      case (mode)
        0:       lut[m] = m[0];
        1:       lut[m] = m[9];
        2:       lut[m] = 1'b0;
        3:       lut[m] = (m == NMIN - 1);
        default: lut[m] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  function automatic logic [WORD_W-1:0] exp_word(input int w);
    logic [WORD_W-1:0] r;
    for (int k = 0; k < WORD_W; k++) r[k] = lut[w * WORD_W + k];
    return r;
  endfunction

  function automatic int exp_ones();
    int n = 0;
    for (int m = 0; m < NMIN; m++) n += int'(lut[m]);
    return n;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_x"}, 64'(x), 64'd0);
    chk({tag, "_valid"}, 64'(wif.word_valid), 64'd0);
    chk({tag, "_data"}, 64'(wif.word_data), 64'd0);
    chk({tag, "_idx"}, 64'(wif.word_idx), 64'd0);
    chk({tag, "_ones"}, 64'(wif.ones_count), 64'd0);
    chk({tag, "_done"}, 64'(wif.done), 64'd0);
  endtask

  // rmode 0: ready high; 1: random ready; 2: 5-cycle stall on word 3; 3: reset in EMIT of word 7
  task automatic run_sweep(input int rmode, input bit pre, input bit chain, input bit mid);
    int k, nw, vcyc, stall, expo;
    bit prev_stall, fin, rdy;
    logic [WORD_W-1:0] hd;
    logic [NIN-1:0]    hi, hx;
    expo = exp_ones();
    nw = 0; vcyc = 0; stall = 0; prev_stall = 0; fin = 0;
    hd = '0; hi = '0; hx = '0;
    if (!pre) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!fin && k < 5000) begin
      if (mid) start = (k == 100);
      if (wif.done) begin
        chk("done_cycle", 64'(k), 64'(1 + NMIN + vcyc));
        if (rmode == 0) chk("done_cycle_nostall", 64'(k), 64'(1 + NWORDS * (WORD_W + 1)));
        if (rmode == 2) chk("done_cycle_stall", 64'(k), 64'(1 + NWORDS * (WORD_W + 1) + 5));
        chk("done_ones", 64'(wif.ones_count), 64'(expo));
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_words", 64'(nw), 64'(NWORDS));
        chk("done_x", 64'(x), 64'd0);
        fin = 1;
        if (chain) start = 1'b1;
      end else begin
        if (k == 1) begin
          chk("first_busy", 64'(busy), 64'd1);
          chk("first_x", 64'(x), 64'd0);
        end
        if (wif.word_valid) begin
          vcyc++;
          if (prev_stall) begin
            chk("hold_data", 64'(wif.word_data), 64'(hd));
            chk("hold_idx", 64'(wif.word_idx), 64'(hi));
            chk("hold_x", 64'(x), 64'(hx));
          end else begin
            chk("word_data", 64'(wif.word_data), 64'(exp_word(nw)));
            chk("word_idx", 64'(wif.word_idx), 64'(nw));
            chk("emit_x", 64'(x), 64'(nw * WORD_W + WORD_W - 1));
            if (nw == 0) chk("first_valid_cycle", 64'(k), 64'(WORD_W + 1));
          end
          hd = wif.word_data; hi = wif.word_idx; hx = x;
          if (rmode == 3 && nw == 7) begin
            rst = 1'b1;
            wif.word_ready = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            chk_reset_vals("abort");
            return;
          end
          if (rmode == 1) rdy = 1'($urandom_range(0, 1));
          else if (rmode == 2 && nw == 3 && stall < 5) begin
            rdy = 1'b0;
            stall++;
          end else rdy = 1'b1;
          wif.word_ready = rdy;
          prev_stall = !rdy;
          if (rdy) nw++;
        end else begin
          wif.word_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
          prev_stall = 0;
        end
        @(negedge clk);
        k++;
      end
    end
    if (rmode == 2) chk("stall_valid_cycles", 64'(vcyc), 64'(NWORDS + 5));
    if (!fin) chk("sweep_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b1;
    start = 1'b0;
    wif.word_ready = 1'b1;
    set_lut(2);
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    set_lut(0);
    run_sweep(0, 0, 0, 0);
    chk("x0_ones", 64'(wif.ones_count), 64'd512);
    chk("x0_last_word", 64'(wif.word_data), 64'h0000_0000_AAAA_AAAA);

    set_lut(1);
    run_sweep(0, 0, 0, 0);
    chk("x9_ones", 64'(wif.ones_count), 64'd512);

    set_lut(2);
    run_sweep(2, 0, 0, 0);
    chk("zero_ones", 64'(wif.ones_count), 64'd0);

    set_lut(3);
    run_sweep(0, 0, 0, 1);
    chk("onehot_ones", 64'(wif.ones_count), 64'd1);
    chk("onehot_last_word", 64'(wif.word_data), 64'h0000_0000_8000_0000);

    set_lut(4);
    run_sweep(3, 0, 0, 0);
    run_sweep(1, 0, 0, 0);

    set_lut(0);
    run_sweep(0, 0, 1, 0);
    run_sweep(0, 1, 0, 0);
    @(negedge clk);
    chk("idle_done_low", 64'(wif.done), 64'd0);
    chk("idle_ones_hold", 64'(wif.ones_count), 64'd512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
